etherneco_synctimer_master_multi: RTL

- Next-generation EtherNeco sync-timer master.
- Owns the fractional-rate master timer and emits the sync command frame with time plus per-node offsets.
- Measures the round-trip from the response frame and filters per-node offset estimates.
- Generalises the previous master: time and offset byte widths, node count and cycle compensation are parameters; it adds error/timeout rejection, busy-guarding of tx_start, and status outputs.

---
 rtl/etherneco_synctimer_master_multi.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/etherneco_synctimer_master_multi.sv
// rtl/etherneco_synctimer_master_multi.sv - EtherNeco sync-timer master with per-node offset filtering
//
// Purpose: fractional-rate master timer, sync command frame generator
// (command byte, timestamp, per-node offsets) and round-trip measurement
// with an IIR filter on the per-node offset estimates.
//
// Optional feature macro: SYNCTIMER_MASTER_MONITOR_EN adds the mon_* outputs.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   current_time               master time (wraps modulo 2^TIMER_WIDTH)
//   set_time, set_valid        time load value and strobe
//   cmd_tx_start/override/correct  start a command frame, command bits 1/0
//   cmd_tx_length              frame length minus 1 (constant)
//   m_cmd_tx_data/last/valid/ready  command frame byte stream
//   res_rx_start/end/error     response frame events
//   res_payload_pos/data/valid response payload bytes
//   busy                       exchange in progress
//   offset_valid               at least one accepted offset update
//   timeout_count, reject_count  saturating event counters
//   mon_response_time, mon_packet_time, mon_measured0  (monitor build only)

module etherneco_synctimer_master_multi #(
  parameter int TIMER_WIDTH    = 64,
  parameter int TIME_BYTES     = 8,
  parameter int NUMERATOR      = 10,
  parameter int DENOMINATOR    = 3,
  parameter int NODES          = 2,
  parameter int OFFSET_BYTES   = 4,
  parameter int OFFSET_GAIN    = 3,
  parameter int TX_COMP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [TIMER_WIDTH-1:0]    current_time,
  input  logic [TIMER_WIDTH-1:0]    set_time,
  input  logic                      set_valid,
  input  logic                      cmd_tx_start,
  input  logic                      cmd_tx_override,
  input  logic                      cmd_tx_correct,
  output logic [15:0]               cmd_tx_length,
  output logic [7:0]                m_cmd_tx_data,
  output logic                      m_cmd_tx_last,
  output logic                      m_cmd_tx_valid,
  input  logic                      m_cmd_tx_ready,
  input  logic                      res_rx_start,
  input  logic                      res_rx_end,
  input  logic                      res_rx_error,
  input  logic [15:0]               res_payload_pos,
  input  logic [7:0]                res_payload_data,
  input  logic                      res_payload_valid,
  output logic                      busy,
  output logic                      offset_valid,
  output logic [7:0]                timeout_count,
  output logic [7:0]                reject_count
`ifdef SYNCTIMER_MASTER_MONITOR_EN
  ,
  output logic [8*OFFSET_BYTES-1:0] mon_response_time,
  output logic [8*OFFSET_BYTES-1:0] mon_packet_time,
  output logic [8*OFFSET_BYTES-1:0] mon_measured0
`endif
);

  localparam int OW        = 8*OFFSET_BYTES;
  localparam int G         = OFFSET_GAIN;
  localparam int NB        = 1 + TIME_BYTES + OFFSET_BYTES*NODES;
  localparam int FW        = 8*NB;
  localparam int INT_STEP  = NUMERATOR / DENOMINATOR;
  localparam int FRAC_STEP = NUMERATOR % DENOMINATOR;
  localparam int COMP      = TX_COMP_CYCLES*NUMERATOR/DENOMINATOR;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_CALC} state_t;

  state_t                 state;
  logic [31:0]            frac;
  logic [31:0]            frac_sum;
  logic [TIMER_WIDTH-1:0] time_latch;
  logic [1:0]             cmd_bits;
  logic [15:0]            byte_idx;
  logic [31:0]            to_cnt;
  logic [1:0]             calc_cnt;
  logic                   got_start;
  logic                   err;
  logic [OW-1:0]          tx_t, resp, rxs, pkt;
  logic [OW-1:0]          offset   [NODES];
  logic [OW-1:0]          rx_off   [NODES];
  logic [OW-1:0]          measured [NODES];
  logic [OW-1:0]          filt     [NODES];
  logic [OW+G-1:0]        acc      [NODES];
  logic [FW-1:0]          frame_vec;
  logic [7:0]             next_byte;

  assign cmd_tx_length = 16'(TIME_BYTES + OFFSET_BYTES*NODES);
  assign busy          = (state != S_IDLE);
  assign frac_sum      = frac + 32'(FRAC_STEP);

  // Fractional timer: integer step each cycle, one extra unit on accumulator carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_time <= '0;
      frac         <= '0;
    end else if (set_valid) begin
      current_time <= set_time;
      frac         <= '0;
    end else if (frac_sum >= 32'(DENOMINATOR)) begin
      current_time <= current_time + TIMER_WIDTH'(INT_STEP + 1);
      frac         <= frac_sum - 32'(DENOMINATOR);
    end else begin
      current_time <= current_time + TIMER_WIDTH'(INT_STEP);
      frac         <= frac_sum;
    end
  end

  // Whole frame as a flat vector; offsets are live so they are sampled at byte issue.
  always_comb begin
    frame_vec = '0;
    frame_vec[7:0] = {6'b0, cmd_bits};
    frame_vec[8 +: 8*TIME_BYTES] = (8*TIME_BYTES)'(time_latch);
    for (int i = 0; i < NODES; i++)
      frame_vec[8*(1 + TIME_BYTES + i*OFFSET_BYTES) +: OW] = offset[i];
    next_byte = 8'h00;
    for (int k = 0; k < NB; k++)
      if (byte_idx == 16'(k)) next_byte = frame_vec[8*k +: 8];
  end

  // Per-node measurement and IIR: off' = (off*(2^G - 2) + measured) >> G.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      measured[i] = resp - rx_off[i] + (pkt << 1);
      acc[i]      = ((OW+G)'(offset[i]) << G) - ((OW+G)'(offset[i]) << 1) + (OW+G)'(measured[i]);
      filt[i]     = offset_valid ? OW'(acc[i] >> G) : (measured[i] >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      m_cmd_tx_valid <= 1'b0;
      m_cmd_tx_data  <= 8'h00;
      m_cmd_tx_last  <= 1'b0;
      byte_idx       <= '0;
      time_latch     <= '0;
      cmd_bits       <= 2'b00;
      to_cnt         <= '0;
      calc_cnt       <= '0;
      got_start      <= 1'b0;
      err            <= 1'b0;
      tx_t           <= '0;
      resp           <= '0;
      rxs            <= '0;
      pkt            <= '0;
      offset_valid   <= 1'b0;
      timeout_count  <= '0;
      reject_count   <= '0;
      for (int i = 0; i < NODES; i++) begin
        offset[i] <= '0;
        rx_off[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_tx_start) begin
            state          <= S_SEND;
            time_latch     <= current_time;
            cmd_bits       <= {cmd_tx_override, cmd_tx_correct};
            tx_t           <= current_time[OW-1:0] - OW'(COMP);
            m_cmd_tx_data  <= {6'b0, cmd_tx_override, cmd_tx_correct};
            m_cmd_tx_valid <= 1'b1;
            m_cmd_tx_last  <= 1'b0;
            byte_idx       <= 16'd1;
            got_start      <= 1'b0;
            err            <= 1'b0;
          end
        end
        S_SEND: begin
          if (m_cmd_tx_valid && m_cmd_tx_ready) begin
            if (m_cmd_tx_last) begin
              m_cmd_tx_valid <= 1'b0;
              m_cmd_tx_last  <= 1'b0;
              state          <= S_WAIT;
              to_cnt         <= '0;
            end else begin
              m_cmd_tx_data <= next_byte;
              m_cmd_tx_last <= (byte_idx == 16'(NB - 1));
              byte_idx      <= byte_idx + 16'd1;
            end
          end
        end
        S_WAIT: begin
          if (res_rx_end) begin
            state    <= S_CALC;
            calc_cnt <= '0;
          end else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state <= S_IDLE;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_CALC: begin
          if (calc_cnt == 2'd0) begin
            if (err) begin
              if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
            end else begin
              for (int i = 0; i < NODES; i++) offset[i] <= filt[i];
              offset_valid <= 1'b1;
            end
          end
          if (calc_cnt == 2'd2) state <= S_IDLE;
          calc_cnt <= calc_cnt + 2'd1;
        end
        default: state <= S_IDLE;
      endcase

      // Response events only count while an exchange is outstanding.
      if (state == S_SEND || state == S_WAIT) begin
        if (res_rx_start) begin
          resp      <= current_time[OW-1:0] - tx_t;
          rxs       <= current_time[OW-1:0];
          got_start <= 1'b1;
        end
        if (res_rx_error && (got_start || res_rx_start)) err <= 1'b1;
        if (res_rx_end) begin
          pkt <= current_time[OW-1:0] - rxs;
          if (!got_start) err <= 1'b1;
        end
        if (res_payload_valid) begin
          for (int i = 0; i < NODES; i++)
            for (int j = 0; j < OFFSET_BYTES; j++)
              if (res_payload_pos == 16'(1 + TIME_BYTES + i*OFFSET_BYTES + j))
                rx_off[i][8*j +: 8] <= res_payload_data;
        end
      end
    end
  end

`ifdef SYNCTIMER_MASTER_MONITOR_EN
  // Snapshot on every CALC entry, rejected exchanges included.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_response_time <= '0;
      mon_packet_time   <= '0;
      mon_measured0     <= '0;
    end else if (state == S_CALC && calc_cnt == 2'd0) begin
      mon_response_time <= resp;
      mon_packet_time   <= pkt;
      mon_measured0     <= measured[0];
    end
  end
`else
  // Monitor outputs and registers are not built.
`endif

endmodule
